// File: rtl/ship_motion.sv
// Per-frame sprite motion: two-key 8-way thrust, saturating velocity with periodic
// friction, and clamped position with wall-contact flags.
module ship_motion #(
  parameter int X_CENTER    = 320,
  parameter int Y_CENTER    = 240,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int SIZE        = 4,
  parameter int ACCEL       = 1,
  parameter int VMAX        = 4,
  parameter int FRIC_PERIOD = 4,
  parameter logic [7:0] KEY_UP    = 8'h1A,
  parameter logic [7:0] KEY_DOWN  = 8'h16,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic [6:0] VelX,
  output logic [6:0] VelY,
  output logic [9:0] Size,
  output logic [2:0] Heading,
  output logic [3:0] WallHit
);

  localparam int CW = (FRIC_PERIOD > 1) ? $clog2(FRIC_PERIOD) : 1;
  localparam logic signed [11:0] VMAX_S  = 12'(VMAX);
  localparam logic signed [11:0] ACCEL_S = 12'(ACCEL);
  localparam logic signed [11:0] X_LO    = 12'(X_MIN + SIZE);
  localparam logic signed [11:0] X_HI    = 12'(X_MAX - SIZE);
  localparam logic signed [11:0] Y_LO    = 12'(Y_MIN + SIZE);
  localparam logic signed [11:0] Y_HI    = 12'(Y_MAX - SIZE);

  logic [9:0]        r_pos_x, r_pos_y;
  logic [6:0]        r_vel_x, r_vel_y;
  logic [2:0]        r_heading;
  logic [3:0]        r_wall;
  logic [CW-1:0]     r_fric_cnt;

  logic              w_up, w_down, w_left, w_right, w_tick;
  logic signed [1:0] w_tx, w_ty;
  logic signed [11:0] w_vx_new, w_vy_new, w_px_sum, w_py_sum;
  logic [9:0]        w_px_n, w_py_n;
  logic [6:0]        w_vx_n, w_vy_n;
  logic [3:0]        w_wall_n;
  logic [2:0]        w_heading_n;
  logic [CW-1:0]     w_fric_cnt_n;

  // Thrust saturates at +/-VMAX; friction only acts on an axis with no thrust.
  function automatic logic signed [11:0] vel_next(input logic [6:0] v,
                                                  input logic signed [1:0] t,
                                                  input logic tick);
    logic signed [11:0] s;
    s = {{5{v[6]}}, v};
    if (t != 2'sd0) begin
      s = (t < 2'sd0) ? (s - ACCEL_S) : (s + ACCEL_S);
      if (s > VMAX_S)       s = VMAX_S;
      else if (s < -VMAX_S) s = -VMAX_S;
    end else if (tick) begin
      if (s > 12'sd0)      s = s - 12'sd1;
      else if (s < 12'sd0) s = s + 12'sd1;
    end
    return s;
  endfunction

  always_comb begin
    w_up    = (keycode0 == KEY_UP)    || (keycode1 == KEY_UP);
    w_down  = (keycode0 == KEY_DOWN)  || (keycode1 == KEY_DOWN);
    w_left  = (keycode0 == KEY_LEFT)  || (keycode1 == KEY_LEFT);
    w_right = (keycode0 == KEY_RIGHT) || (keycode1 == KEY_RIGHT);
    w_ty    = (w_up && !w_down) ? -2'sd1 : ((w_down && !w_up) ? 2'sd1 : 2'sd0);
    w_tx    = (w_left && !w_right) ? -2'sd1 : ((w_right && !w_left) ? 2'sd1 : 2'sd0);

    w_tick       = (r_fric_cnt == '0);
    w_fric_cnt_n = (r_fric_cnt == CW'(FRIC_PERIOD - 1)) ? '0 : r_fric_cnt + 1'b1;

    w_vx_new = vel_next(r_vel_x, w_tx, w_tick);
    w_vy_new = vel_next(r_vel_y, w_ty, w_tick);
    w_px_sum = $signed({2'b00, r_pos_x}) + w_vx_new;
    w_py_sum = $signed({2'b00, r_pos_y}) + w_vy_new;

    w_wall_n = 4'b0000;
    w_px_n   = w_px_sum[9:0];
    w_vx_n   = w_vx_new[6:0];
    if (w_px_sum < X_LO) begin
      w_px_n      = X_LO[9:0];
      w_vx_n      = 7'd0;
      w_wall_n[3] = 1'b1;
    end else if (w_px_sum > X_HI) begin
      w_px_n      = X_HI[9:0];
      w_vx_n      = 7'd0;
      w_wall_n[2] = 1'b1;
    end
    w_py_n = w_py_sum[9:0];
    w_vy_n = w_vy_new[6:0];
    if (w_py_sum < Y_LO) begin
      w_py_n      = Y_LO[9:0];
      w_vy_n      = 7'd0;
      w_wall_n[1] = 1'b1;
    end else if (w_py_sum > Y_HI) begin
      w_py_n      = Y_HI[9:0];
      w_vy_n      = 7'd0;
      w_wall_n[0] = 1'b1;
    end

    // Clockwise from north; no thrust keeps the previous heading.
    w_heading_n = r_heading;
    case ({w_tx, w_ty})
      4'b00_11: w_heading_n = 3'd0;
      4'b01_11: w_heading_n = 3'd1;
      4'b01_00: w_heading_n = 3'd2;
      4'b01_01: w_heading_n = 3'd3;
      4'b00_01: w_heading_n = 3'd4;
      4'b11_01: w_heading_n = 3'd5;
      4'b11_00: w_heading_n = 3'd6;
      4'b11_11: w_heading_n = 3'd7;
      default:  w_heading_n = r_heading;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_pos_x    <= 10'(X_CENTER);
      r_pos_y    <= 10'(Y_CENTER);
      r_vel_x    <= '0;
      r_vel_y    <= '0;
      r_heading  <= '0;
      r_wall     <= '0;
      r_fric_cnt <= '0;
    end else if (enable) begin
      r_pos_x    <= w_px_n;
      r_pos_y    <= w_py_n;
      r_vel_x    <= w_vx_n;
      r_vel_y    <= w_vy_n;
      r_heading  <= w_heading_n;
      r_wall     <= w_wall_n;
      r_fric_cnt <= w_fric_cnt_n;
    end
  end

  assign PosX    = r_pos_x;
  assign PosY    = r_pos_y;
  assign VelX    = r_vel_x;
  assign VelY    = r_vel_y;
  assign Size    = 10'(SIZE);
  assign Heading = r_heading;
  assign WallHit = r_wall;

endmodule

// File: tb/tb_ship_motion.sv
// Bench for ship_motion: two instances (default and fast-friction/short-Y) driven by
// shared directed and random key streams, checked against a per-frame arithmetic model.
module tb_ship_motion;

  localparam int B_YMIN = 10, B_YMAX = 69, B_YCEN = 40;

  logic       Reset, frame_clk, enable;
  logic [7:0] keycode0, keycode1;
  logic [9:0] a_px, a_py, a_size, b_px, b_py, b_size;
  logic [6:0] a_vx, a_vy, b_vx, b_vy;
  logic [2:0] a_hd, b_hd;
  logic [3:0] a_wh, b_wh;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  ship_motion dut_a (
    .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
    .keycode0(keycode0), .keycode1(keycode1),
    .PosX(a_px), .PosY(a_py), .VelX(a_vx), .VelY(a_vy),
    .Size(a_size), .Heading(a_hd), .WallHit(a_wh)
  );

  ship_motion #(.FRIC_PERIOD(1), .Y_MIN(B_YMIN), .Y_MAX(B_YMAX), .Y_CENTER(B_YCEN)) dut_b (
    .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
    .keycode0(keycode0), .keycode1(keycode1),
    .PosX(b_px), .PosY(b_py), .VelX(b_vx), .VelY(b_vy),
    .Size(b_size), .Heading(b_hd), .WallHit(b_wh)
  );

  // clock / reset
  initial frame_clk = 1'b0;
  always #10 frame_clk = ~frame_clk;

  // ---------------- behavioural model ----------------
  int m_px[2], m_py[2], m_vx[2], m_vy[2], m_hd[2], m_wh[2], m_frames[2];
  int hd_tab[9] = '{7, 6, 5, 0, -1, 4, 1, 2, 3};

  function automatic int dir(input logic [7:0] k0, input logic [7:0] k1,
                             input logic [7:0] neg, input logic [7:0] pos);
    bit n, p;
    n = (k0 == neg) || (k1 == neg);
    p = (k0 == pos) || (k1 == pos);
    return (n && !p) ? -1 : ((p && !n) ? 1 : 0);
  endfunction

  function automatic int vstep(input int v, input int t, input bit tick, input int vmax);
    int r;
    if (t != 0) begin
      r = v + t;
      if (r > vmax) r = vmax;
      if (r < -vmax) r = -vmax;
    end else if (tick) r = (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
    else r = v;
    return r;
  endfunction

  task automatic model_reset(input int i, input int ycen);
    m_px[i] = 320; m_py[i] = ycen; m_vx[i] = 0; m_vy[i] = 0;
    m_hd[i] = 0; m_wh[i] = 0; m_frames[i] = 0;
  endtask

  task automatic model_step(input int i, input int ymin, input int ymax, input int fp);
    int tx, ty, h, nx, ny, vx, vy;
    bit tick;
    tx = dir(keycode0, keycode1, 8'h04, 8'h07);
    ty = dir(keycode0, keycode1, 8'h1A, 8'h16);
    tick = (m_frames[i] % fp) == 0;
    m_frames[i]++;
    vx = vstep(m_vx[i], tx, tick, 4);
    vy = vstep(m_vy[i], ty, tick, 4);
    nx = m_px[i] + vx;
    ny = m_py[i] + vy;
    m_wh[i] = 0;
    if (nx < 4)        begin nx = 4;        vx = 0; m_wh[i] |= 8; end
    else if (nx > 635) begin nx = 635;      vx = 0; m_wh[i] |= 4; end
    if (ny < ymin + 4) begin ny = ymin + 4; vy = 0; m_wh[i] |= 2; end
    else if (ny > ymax - 4) begin ny = ymax - 4; vy = 0; m_wh[i] |= 1; end
    h = hd_tab[(tx + 1) * 3 + (ty + 1)];
    if (h >= 0) m_hd[i] = h;
    m_px[i] = nx; m_py[i] = ny; m_vx[i] = vx; m_vy[i] = vy;
  endtask

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      model_reset(0, 240);
      model_reset(1, B_YCEN);
    end else if (enable) begin
      model_step(0, 0, 479, 4);
      model_step(1, B_YMIN, B_YMAX, 1);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge frame_clk) begin
    if (started && !Reset) begin
      chk("a_posx", int'(a_px), m_px[0]);
      chk("a_posy", int'(a_py), m_py[0]);
      chk("a_velx", int'($signed(a_vx)), m_vx[0]);
      chk("a_vely", int'($signed(a_vy)), m_vy[0]);
      chk("a_head", int'(a_hd), m_hd[0]);
      chk("a_wall", int'(a_wh), m_wh[0]);
      chk("b_posx", int'(b_px), m_px[1]);
      chk("b_posy", int'(b_py), m_py[1]);
      chk("b_velx", int'($signed(b_vx)), m_vx[1]);
      chk("b_vely", int'($signed(b_vy)), m_vy[1]);
      chk("b_head", int'(b_hd), m_hd[1]);
      chk("b_wall", int'(b_wh), m_wh[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic frames(input int n);
    repeat (n) @(negedge frame_clk);
    #1;
  endtask

  task automatic set_keys(input logic [7:0] k0, input logic [7:0] k1);
    keycode0 = k0;
    keycode1 = k1;
  endtask

  task automatic reset_pulse();
    Reset = 1'b1;
    #1;
    chk("rst_a_posx", int'(a_px), 320);
    chk("rst_a_posy", int'(a_py), 240);
    chk("rst_a_velx", int'($signed(a_vx)), 0);
    chk("rst_a_head", int'(a_hd), 0);
    chk("rst_b_posy", int'(b_py), B_YCEN);
    chk("rst_b_wall", int'(b_wh), 0);
    #1;
    Reset = 1'b0;
  endtask

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h1A;
      2: return 8'h16;
      3: return 8'h04;
      4: return 8'h07;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  int exp_vx[6] = '{1, 2, 3, 4, 4, 4};
  int exp_px[6] = '{321, 323, 326, 330, 334, 338};
  int fr_vx[5]  = '{3, 2, 1, 0, 0};
  int fr_px[5]  = '{341, 343, 344, 344, 344};

  initial begin
    Reset = 1'b0; enable = 1'b1;
    set_keys(8'h00, 8'h00);
    #1 Reset = 1'b1;
    frames(2);
    chk("reset_posx", int'(a_px), 320);
    chk("reset_posy", int'(a_py), 240);
    chk("reset_velx", int'($signed(a_vx)), 0);
    chk("reset_vely", int'($signed(a_vy)), 0);
    chk("reset_head", int'(a_hd), 0);
    chk("reset_wall", int'(a_wh), 0);
    chk("size", int'(a_size), 4);
    Reset = 1'b0;
    started = 1'b1;

    // hold D for six frames
    set_keys(8'h07, 8'h00);
    for (int i = 0; i < 6; i++) begin
      frames(1);
      chk("hold_d_velx", int'($signed(a_vx)), exp_vx[i]);
      chk("hold_d_posx", int'(a_px), exp_px[i]);
      chk("hold_d_b_posx", int'(b_px), exp_px[i]);
    end
    chk("hold_d_head", int'(a_hd), 2);

    // release: friction every frame on dut_b
    set_keys(8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      frames(1);
      chk("fric_velx", int'($signed(b_vx)), fr_vx[i]);
      chk("fric_posx", int'(b_px), fr_px[i]);
    end
    chk("fric_head", int'(b_hd), 2);

    // diagonal, then opposing X keys
    reset_pulse();
    set_keys(8'h1A, 8'h07);
    frames(1);
    chk("diag_velx", int'($signed(a_vx)), 1);
    chk("diag_vely", int'($signed(a_vy)), -1);
    chk("diag_posx", int'(a_px), 321);
    chk("diag_posy", int'(a_py), 239);
    chk("diag_head", int'(a_hd), 1);
    set_keys(8'h04, 8'h07);
    frames(1);
    chk("opp_a_velx", int'($signed(a_vx)), 1);
    chk("opp_a_posx", int'(a_px), 322);
    chk("opp_a_posy", int'(a_py), 238);
    chk("opp_a_head", int'(a_hd), 1);
    chk("opp_b_velx", int'($signed(b_vx)), 0);
    chk("opp_b_vely", int'($signed(b_vy)), 0);
    chk("opp_b_posx", int'(b_px), 321);
    chk("opp_b_posy", int'(b_py), 39);

    // drive into the left wall
    reset_pulse();
    set_keys(8'h04, 8'h00);
    frames(80);
    chk("pre_wall_posx", int'(a_px), 6);
    chk("pre_wall_velx", int'($signed(a_vx)), -4);
    frames(1);
    chk("wall_posx", int'(a_px), 4);
    chk("wall_velx", int'($signed(a_vx)), 0);
    chk("wall_hit", int'(a_wh), 4'b1000);
    frames(1);
    chk("wall2_posx", int'(a_px), 4);
    chk("wall2_hit", int'(a_wh), 4'b1000);
    set_keys(8'h00, 8'h00);
    frames(1);
    chk("wall_rel_hit", int'(a_wh), 0);
    chk("wall_rel_posx", int'(a_px), 4);

    // enable low while holding D
    enable = 1'b0;
    set_keys(8'h07, 8'h00);
    frames(5);
    chk("hold_en_posx", int'(a_px), 4);
    chk("hold_en_velx", int'($signed(a_vx)), 0);
    chk("hold_en_head", int'(a_hd), 6);
    chk("hold_en_wall", int'(a_wh), 0);
    enable = 1'b1;
    frames(3);
    reset_pulse();

    // random key streams
    for (int n = 0; n < 3000; ) begin
      int len;
      set_keys(pick_key(), pick_key());
      len = $urandom_range(1, 30);
      for (int j = 0; j < len; j++) begin
        enable = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 299) == 0) reset_pulse();
        frames(1);
        n++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ship_motion.md
# ship_motion

Frame-rate motion engine for one player sprite: decodes up to two simultaneous keycodes into 8-way thrust, integrates a saturating signed velocity with acceleration and periodic friction, and clamps position to a parametrised playfield with wall-contact flags. It is the parametrised successor to the single-key, constant-step ball mover. It updates once per `frame_clk` (VSYNC-derived) and feeds the sprite renderer and collision logic.

## Interface
Parameters:
- `X_CENTER`, default 320: reset X position.
- `Y_CENTER`, default 240: reset Y position.
- `X_MIN` / `X_MAX`, default 0 / 639: playfield X bounds.
- `Y_MIN` / `Y_MAX`, default 0 / 479: playfield Y bounds.
- `SIZE`, default 4: sprite half-extent in pixels.
- `ACCEL`, default 1: velocity change per thrust frame.
- `VMAX`, default 4: velocity magnitude limit, 1..63.
- `FRIC_PERIOD`, default 4: frames between friction decrements, ≥1.
- `KEY_UP` / `KEY_DOWN` / `KEY_LEFT` / `KEY_RIGHT`, default 8'h1A / 8'h16 / 8'h04 / 8'h07: USB HID keycodes for W/S/A/D.

Ports:
- `Reset`, in, 1: reset; asynchronous, active-high.
- `frame_clk`, in, 1: clock; one rising edge per video frame.
- `enable`, in, 1: high = update this frame; low = hold all state.
- `keycode0`, `keycode1`, in, 8 each: currently pressed keys; 0 = none.
- `PosX`, `PosY`, out, 10 each: sprite centre.
- `VelX`, `VelY`, out, 7 each: signed two's-complement velocity.
- `Size`, out, 10: constant `SIZE`.
- `Heading`, out, 3: last thrust direction; 0=N, 1=NE, 2=E, … 7=NW (clockwise).
- `WallHit`, out, 4: {left, right, top, bottom}; high for any frame in which that clamp engaged.

## Operation
- Reset values: `PosX`=`X_CENTER`, `PosY`=`Y_CENTER`, `VelX`=`VelY`=0, `Heading`=0, `WallHit`=0, friction counter=0.
- Key decode per axis: a direction is pressed if either keycode equals its code. Up-only gives ty=−1; down-only gives ty=+1; both or neither gives ty=0. tx is decoded the same way from left/right.
- Friction tick: internal counter runs 0..`FRIC_PERIOD`−1 and advances on every enabled frame. The tick is true when the counter is 0 before the advance.
- Velocity, per axis:
  - If t≠0: v' = sat(v + t·`ACCEL`, −`VMAX`, +`VMAX`).
  - If t=0 and tick: v moves 1 toward 0.
  - Otherwise v' = v.
- Position uses the new velocity in the same frame: p' = p + v'. Compute in signed 12-bit with no wrap.
- Clamp:
  - If p' < MIN+`SIZE`: p'=MIN+`SIZE`, v'=0, set the left/top `WallHit` bit.
  - If p' > MAX−`SIZE`: p'=MAX−`SIZE`, v'=0, set the right/bottom `WallHit` bit.
  - `WallHit` bits not set this frame are cleared.
- Heading: when (tx,ty)≠(0,0), it takes the 8-way code of the thrust vector. Otherwise it holds.
- `enable`=0: no register changes, including the counter. `WallHit` holds.
- Keycodes other than the four directions are ignored.

## Timing
- All outputs are registered on the `frame_clk` rising edge. Keys sampled at edge k are reflected in Vel/Pos/Heading at edge k (zero-frame latency).
- Velocity and position update on the same edge. There is no stale-velocity frame.
- A clamp zeroes velocity on the same edge as the position clamp. Continued thrust into a wall re-clamps and re-asserts `WallHit` every frame.
- `Reset` asserted mid-motion returns every output to its reset value immediately, without waiting for a clock. The first edge after release is a normal update with counter=0.

## Test plan
- Reset: assert `Reset` → Pos (320,240), Vel (0,0), `Heading`=0, `WallHit`=0.
- Hold D (`keycode0`=8'h07), 6 frames, defaults → `VelX` 1,2,3,4,4,4 and `PosX` 321,323,326,330,334,338, `Heading`=2.
- Friction with `FRIC_PERIOD`=1: from `VelX`=4 at `PosX`=338, release keys → `VelX` 3,2,1,0,0 and `PosX` 341,343,344,344,344; `Heading` stays 2.
- Diagonal and opposing keys:
  - `keycode0`=8'h1A, `keycode1`=8'h07 for 1 frame from reset → Vel (1,−1), Pos (321,239), `Heading`=1.
  - Then `keycode0`=8'h04, `keycode1`=8'h07 → no X thrust; `VelX` follows the friction rule.
- Wall: preload `PosX`=6, `VelX`=−3, hold A → next frame `PosX`=4, `VelX`=0, `WallHit`=4'b1000. The following frame gives `PosX`=4 and `WallHit`=4'b1000 again. Release → `WallHit`=0.
- `enable`=0 for 5 frames while holding D → all outputs unchanged.
- `Reset` pulse between edges mid-motion → outputs return to reset values immediately.
